// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Adds two (4*NIBBLES)-bit operands one nibble at a time, LSB nibble first.
//   All arithmetic is done by one external 4-bit combinational adder that has
//   no carry-in. When a nibble has an incoming carry, the controller makes a
//   second pass (INC) that adds that carry to the partial sum.
//
//   Build option:
//     FIXED_LATENCY_EN - when defined, the INC pass is always executed. It adds
//                        0 or 1, so the unit is busy for exactly 2*NIBBLES
//                        cycles. The results are the same either way.
//
//   Ports:
//     clk, rst     rising-edge clock; synchronous active-high reset
//     start        request, sampled only in IDLE
//     a, b         operands, latched when start is accepted
//     busy         high in ADD/INC
//     done         one-cycle pulse; sum/cout valid
//     sum, cout    result; held until the next accepted start
//     add_x/add_y  operands driven to the shared adder (0 when idle)
//     add_s/add_cout  result coming back from the shared adder
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic [3:0]           add_x,
    output logic [3:0]           add_y,
    input  logic [3:0]           add_s,
    input  logic                 add_cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_INC,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [W-1:0]  a_q, b_q;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic [IW-1:0] idx;
    logic          carry;
    logic [3:0]    part;
    logic          c1;

    logic          accept;
    logic          wr_nib;
    logic          adv;
    logic          new_carry;
    logic [3:0]    a_nib, b_nib;

    assign a_nib  = 4'(a_q >> {idx, 2'b00});
    assign b_nib  = 4'(b_q >> {idx, 2'b00});
    assign accept = (state == S_IDLE) && start;

    assign busy = (state == S_ADD) || (state == S_INC);
    assign done = (state == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        add_x     = 4'h0;
        add_y     = 4'h0;
        wr_nib    = 1'b0;
        adv       = 1'b0;
        new_carry = carry;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ADD;
                end
            end
            S_ADD: begin
                add_x = a_nib;
                add_y = b_nib;
`ifdef FIXED_LATENCY_EN
                state_n = S_INC;
`else
                if (carry) begin
                    state_n = S_INC;
                end else begin
                    wr_nib    = 1'b1;
                    new_carry = add_cout;
                    adv       = 1'b1;
                end
`endif
            end
            S_INC: begin
                // The partial sum and the incoming carry cannot both produce a
                // carry, so OR-ing the two carries is exact.
                add_x     = part;
                add_y     = {3'b000, carry};
                wr_nib    = 1'b1;
                new_carry = c1 | add_cout;
                adv       = 1'b1;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (adv) begin
            state_n = (idx == LAST) ? S_DONE : S_ADD;
        end
    end

    // Control and result registers; an aborted op leaves sum/cout cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            if (accept) begin
                idx   <= '0;
                carry <= 1'b0;
            end
            if (wr_nib) begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx == IW'(i)) begin
                        sum_q[4*i +: 4] <= add_s;
                    end
                end
            end
            if (adv) begin
                carry <= new_carry;
                if (idx == LAST) begin
                    cout_q <= new_carry;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    // Operand latches and first-pass capture need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
        if (state == S_ADD) begin
            part <= add_s;
            c1   <= add_cout;
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl
//   Directed bench for nibble_serial_add_ctrl. One instance uses NIBBLES=4
//   and another uses NIBBLES=1. Each instance has a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FIXED_LATENCY_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif

    logic        rst, start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  add_x, add_y, add_s;
    logic        add_cout;

    assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y};

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .add_x(add_x), .add_y(add_y), .add_s(add_s), .add_cout(add_cout)
    );

    logic       start1;
    logic [3:0] a1, b1;
    logic       busy1, done1;
    logic [3:0] sum1;
    logic       cout1;
    logic [3:0] x1, y1, s1;
    logic       co1;

    assign {co1, s1} = {1'b0, x1} + {1'b0, y1};

    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .add_x(x1), .add_y(y1), .add_s(s1), .add_cout(co1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on the 4-nibble instance. The operands are scrambled after
    // acceptance, and the bench counts busy/done cycles over a fixed window.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input bit mid_pulse,
                         output int nb, output int nd, output logic [3:0] x0, output logic [3:0] y0);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v;
        x0 = add_x; y0 = add_y;
        nb = 0; nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy) nb++;
            if (done) nd++;
            if (mid_pulse) start = (k == 1);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, nd, lb;
        logic [3:0] x0, y0;
        logic bz [0:39];
        logic dn [0:39];
        logic [15:0] sv [0:39];

        lb = FIX ? 8 : 4;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;

        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_addx", 32'(add_x), 32'd0);
        check("rst_addy", 32'(add_y), 32'd0);

        // 2. simple add, no carries
        do_op(16'h0001, 16'h0002, 1'b0, nb, nd, x0, y0);
        check("t2_x0", 32'(x0), 32'h1);
        check("t2_y0", 32'(y0), 32'h2);
        check("t2_sum", 32'(sum), 32'h0003);
        check("t2_cout", 32'(cout), 32'd0);
        check("t2_busy", 32'(nb), 32'(lb));
        check("t2_done", 32'(nd), 32'd1);
        check("idle_addx", 32'(add_x), 32'd0);

        // 3. carry rippling through every nibble
        do_op(16'hFFFF, 16'h0001, 1'b0, nb, nd, x0, y0);
        check("t3a_x0", 32'(x0), 32'hF);
        check("t3a_y0", 32'(y0), 32'h1);
        check("t3a_sum", 32'(sum), 32'h0000);
        check("t3a_cout", 32'(cout), 32'd1);
        check("t3a_busy", 32'(nb), FIX ? 32'd8 : 32'd7);
        check("t3a_done", 32'(nd), 32'd1);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, nb, nd, x0, y0);
        check("t3b_sum", 32'(sum), 32'hFFFE);
        check("t3b_cout", 32'(cout), 32'd1);
        check("t3b_busy", 32'(nb), FIX ? 32'd8 : 32'd7);
        check("t3b_done", 32'(nd), 32'd1);

        // mid-op start pulse must be ignored
        do_op(16'h0001, 16'h0002, 1'b1, nb, nd, x0, y0);
        check("mid_sum", 32'(sum), 32'h0003);
        check("mid_busy", 32'(nb), 32'(lb));
        check("mid_done", 32'(nd), 32'd1);

        // 4. start held high: back-to-back operations
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bz[k] = busy; dn[k] = done; sv[k] = sum;
        end
        check("t4_busy1", 32'(bz[lb-1]), 32'd1);
        check("t4_done1", 32'(dn[lb]), 32'd1);
        check("t4_sum1", 32'(sv[lb]), 32'h5555);
        check("t4_gap_busy", 32'(bz[lb+1]), 32'd0);
        check("t4_gap_done", 32'(dn[lb+1]), 32'd0);
        check("t4_busy2", 32'(bz[lb+2]), 32'd1);
        check("t4_done2", 32'(dn[2*lb+2]), 32'd1);
        check("t4_sum2", 32'(sv[2*lb+2]), 32'h5555);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("t4_settle_sum", 32'(sum), 32'h5555);

        // 5. reset during the third busy cycle
        a = 16'hFFFF; b = 16'h0001; start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_sum", 32'(sum), 32'h0);
        check("t5_cout", 32'(cout), 32'd0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("t5_nodone", 32'(nd), 32'd0);
        do_op(16'hFFFF, 16'h0001, 1'b0, nb, nd, x0, y0);
        check("t5_re_sum", 32'(sum), 32'h0000);
        check("t5_re_cout", 32'(cout), 32'd1);
        check("t5_re_busy", 32'(nb), FIX ? 32'd8 : 32'd7);
        check("t5_re_done", 32'(nd), 32'd1);

        // 6. NIBBLES=1 exhaustive
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                a1 = 4'(i); b1 = 4'(j); start1 = 1'b1;
                @(negedge clk);
                start1 = 1'b0; a1 = ~a1; b1 = ~b1;
                nb = 0; nd = 0;
                for (int k = 0; k < 5; k++) begin
                    if (busy1) nb++;
                    if (done1) nd++;
                    @(negedge clk);
                end
                check($sformatf("n1_sum_%0d_%0d", i, j), 32'({cout1, sum1}), 32'(i + j));
                check($sformatf("n1_busy_%0d_%0d", i, j), 32'(nb), FIX ? 32'd2 : 32'd1);
                check($sformatf("n1_done_%0d_%0d", i, j), 32'(nd), 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
